instruction_fetch: RTL and testbench

- Stage directly downstream of program_counter. Takes the PC's current address, fetches that word from instruction memory over a req/gnt/rvalid handshake, and buffers {pc, instr} pairs in a small queue.
- The decode stage drains the queue through a valid/ready handshake.
- A flush from branch/jump resolution discards everything buffered or in flight, so the redirected PC stream starts clean.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instruction_fetch.sv | 124 ++++++++++++
 tb/tb_instruction_fetch.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // One outstanding fetch at most; DRAIN swallows the response of a
  // request that a flush has killed after it was granted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Queue entry for the default address/data widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// The head is read straight from storage registers, so the outputs never
// depend combinationally on the write data.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic                   head_valid_o,
  output logic [WIDTH-1:0]       head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage: cleared on reset so the head reads zero before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; clear wins over a coincident push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: accepts a PC, fetches the word over req/gnt/rvalid and
// queues {pc, instr} for decode. A flush empties the queue and kills any
// fetch still in flight.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready
);

  localparam int CW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic [CW:0]       count;
  logic              head_valid;
  logic [EW-1:0]     head_data;

  // DEPTH is a power of two, so the queue is full exactly when the count MSB is set.
  assign pc_ready = (state_q == IDLE) && !count[CW] && !flush;
  assign accept   = pc_valid && pc_ready;
  assign pop      = head_valid && id_ready && !flush;

  // Next-state logic; flush takes priority over every normal transition.
  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    req_pc_d    = req_pc_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = REQ;
          imem_addr_d = {pc_addr[ADDR_W-1:2], 2'b00};
          req_pc_d    = pc_addr;
        end
      end
      REQ: begin
        if (flush) begin
          state_d = imem_gnt ? DRAIN : IDLE;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          push    = !flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    imem_req_d = (state_d == REQ);
  end

  // FSM state and registered memory request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      req_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      req_pc_q    <= req_pc_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  ({req_pc_q, imem_rdata}),
    .pop_i        (pop),
    .clear_i      (flush),
    .head_valid_o (head_valid),
    .head_data_o  (head_data),
    .count_o      (count)
  );

  assign id_valid = head_valid;
  assign id_pc    = head_data[EW-1:DATA_W];
  assign id_instr = head_data[DATA_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized
// run against a transaction-level model of the fetch queue.
module tb_instruction_fetch;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_addr;
  logic          pc_valid;
  logic          pc_ready;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          flush;
  logic          id_valid;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready;

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: queue of expected entries plus one fetch lifecycle.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;
  ent_t          mq[$];
  logic          busy, granted, killed;
  logic [AW-1:0] m_pc, m_addr;
  // Memory responder state.
  logic          m_pend;
  int            m_dly;
  logic [DW-1:0] m_pdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch: accept, grant in the request cycle, data one cycle later.
  task automatic fetch0(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_a;
    exp_a = {a[31:2], 2'b00};
    pc_valid = 1'b1; pc_addr = a;
    #1; chk1("f_pc_ready", pc_ready, 1'b1);
    nxt();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    #1; chk1("f_req", imem_req, 1'b1); chk32("f_addr", imem_addr, exp_a);
    nxt();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d;
    #1; chk1("f_req_low", imem_req, 1'b0);
    nxt();
    imem_rvalid = 1'b0; imem_rdata = '0;
  endtask

  // Advance the reference model by one clock edge using the inputs just applied.
  task automatic model_edge();
    logic acc, do_pop, do_push;
    acc     = !busy && pc_valid && !flush && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && id_ready && !flush;
    do_push = busy && granted && imem_rvalid && !killed && !flush;
    if (flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: m_pc, instr: imem_rdata});
    end
    if (busy) begin
      if (!granted) begin
        if (imem_gnt) begin granted = 1'b1; killed = flush; end
        else if (flush) busy = 1'b0;
      end else begin
        if (imem_rvalid) busy = 1'b0;
        else if (flush) killed = 1'b1;
      end
    end else if (acc) begin
      busy = 1'b1; granted = 1'b0; killed = 1'b0;
      m_pc = pc_addr; m_addr = {pc_addr[31:2], 2'b00};
    end
    if (imem_rvalid) m_pend = 1'b0;
    else if (m_pend) m_dly--;
    if (imem_gnt) begin
      m_pend = 1'b1; m_dly = $urandom_range(0, 2); m_pdata = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_addr = '0; pc_valid = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; flush = 1'b0; id_ready = 1'b0;
    #3;
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk32("rst_id_instr", id_instr, 32'h0);
    chk32("rst_id_pc", id_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Asynchronous reset while a request to 0x40 is pending.
    pc_valid = 1'b1; pc_addr = 32'h40;
    #1; chk1("t1_ready", pc_ready, 1'b1);
    nxt();
    pc_valid = 1'b0;
    #1; chk1("t1_req", imem_req, 1'b1); chk32("t1_addr", imem_addr, 32'h40);
    #2; rst = 1'b1;
    #1; chk1("t1_rst_req", imem_req, 1'b0); chk32("t1_rst_addr", imem_addr, 32'h0);
    chk1("t1_rst_idv", id_valid, 1'b0); chk1("t1_rst_idle", pc_ready, 1'b1);
    #1; rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD0BAD;
    nxt();
    imem_rvalid = 1'b0;
    #1; chk1("t1_late_resp", id_valid, 1'b0); chk1("t1_req_after", imem_req, 1'b0);
    chk1("t1_ready_after", pc_ready, 1'b1);
    nxt();

    // Zero-wait fetch of 0x10.
    id_ready = 1'b1;
    fetch0(32'h10, 32'hDEADBEEF);
    #1; chk1("t2_idv", id_valid, 1'b1); chk32("t2_pc", id_pc, 32'h10);
    chk32("t2_instr", id_instr, 32'hDEADBEEF);
    nxt();
    #1; chk1("t2_popped", id_valid, 1'b0);

    // Backpressure: fill the queue, verify stall, then drain in order.
    id_ready = 1'b0;
    fetch0(32'h0, 32'h11110000);
    fetch0(32'h4, 32'h11110004);
    pc_valid = 1'b1; pc_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1; chk1("t3_ready_low", pc_ready, 1'b0); chk1("t3_no_req", imem_req, 1'b0);
      chk1("t3_idv", id_valid, 1'b1); chk32("t3_hold_pc", id_pc, 32'h0);
      chk32("t3_hold_instr", id_instr, 32'h11110000);
      nxt();
    end
    pc_valid = 1'b0; id_ready = 1'b1;
    #1; chk32("t3_pop0", id_pc, 32'h0);
    nxt();
    #1; chk32("t3_pop1_pc", id_pc, 32'h4); chk32("t3_pop1_instr", id_instr, 32'h11110004);
    chk1("t3_ready_back", pc_ready, 1'b1);
    nxt();
    #1; chk1("t3_empty", id_valid, 1'b0);
    fetch0(32'h8, 32'h11110008);
    #1; chk1("t3_resume_v", id_valid, 1'b1); chk32("t3_resume_pc", id_pc, 32'h8);
    nxt();

    // Delayed grant on an unaligned PC.
    pc_valid = 1'b1; pc_addr = 32'h7;
    #1; chk1("t4_ready", pc_ready, 1'b1);
    nxt();
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk1("t4_req_hold", imem_req, 1'b1); chk32("t4_addr_hold", imem_addr, 32'h4);
      nxt();
    end
    imem_gnt = 1'b1;
    #1; chk1("t4_req_gnt", imem_req, 1'b1);
    nxt();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE0007;
    #1; chk1("t4_req_low", imem_req, 1'b0);
    nxt();
    imem_rvalid = 1'b0;
    #1; chk1("t4_idv", id_valid, 1'b1); chk32("t4_pc", id_pc, 32'h7);
    chk32("t4_instr", id_instr, 32'hCAFE0007);
    nxt();

    // Flush in WAIT with a queued entry; the late response must be dropped.
    id_ready = 1'b0;
    fetch0(32'h20, 32'hA0A0A0A0);
    pc_valid = 1'b1; pc_addr = 32'h24;
    #1; nxt();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    #1; chk1("t5_req", imem_req, 1'b1);
    nxt();
    imem_gnt = 1'b0; flush = 1'b1;
    #1; chk1("t5_ready_flush", pc_ready, 1'b0); chk1("t5_idv_before", id_valid, 1'b1);
    nxt();
    flush = 1'b0; pc_valid = 1'b1; pc_addr = 32'h80;
    #1; chk1("t5_cleared", id_valid, 1'b0); chk1("t5_drain_ready", pc_ready, 1'b0);
    chk1("t5_drain_req", imem_req, 1'b0);
    nxt();
    #1; chk1("t5_drain_hold", pc_ready, 1'b0);
    nxt();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234;
    #1; nxt();
    imem_rvalid = 1'b0;
    #1; chk1("t5_dropped", id_valid, 1'b0); chk1("t5_ready_back", pc_ready, 1'b1);
    id_ready = 1'b1;
    fetch0(32'h80, 32'h80808080);
    #1; chk1("t5_first_v", id_valid, 1'b1); chk32("t5_first_pc", id_pc, 32'h80);
    chk32("t5_first_instr", id_instr, 32'h80808080);
    nxt();
    #1; chk1("t5_after", id_valid, 1'b0);

    // Flush coinciding with grant; response two cycles later is discarded.
    pc_valid = 1'b1; pc_addr = 32'h100;
    #1; chk1("t6_ready", pc_ready, 1'b1);
    nxt();
    pc_valid = 1'b0; imem_gnt = 1'b1; flush = 1'b1;
    #1; chk1("t6_req", imem_req, 1'b1);
    nxt();
    imem_gnt = 1'b0; flush = 1'b0;
    #1; chk1("t6_req_low", imem_req, 1'b0); chk1("t6_drain", pc_ready, 1'b0);
    nxt();
    imem_rvalid = 1'b1; imem_rdata = 32'h5555;
    #1; chk1("t6_still_drain", pc_ready, 1'b0);
    nxt();
    imem_rvalid = 1'b0;
    #1; chk1("t6_ready_back", pc_ready, 1'b1); chk1("t6_no_push", id_valid, 1'b0);

    // Flush in REQ without grant returns straight to IDLE.
    pc_valid = 1'b1; pc_addr = 32'h200;
    #1; nxt();
    pc_valid = 1'b0; flush = 1'b1;
    #1; chk1("t7_req", imem_req, 1'b1); chk1("t7_ready_flush", pc_ready, 1'b0);
    nxt();
    flush = 1'b0;
    #1; chk1("t7_req_drop", imem_req, 1'b0); chk1("t7_idle", pc_ready, 1'b1);
    chk32("t7_addr", imem_addr, 32'h200);

    // Flush together with rvalid in WAIT: response discarded, back to IDLE.
    pc_valid = 1'b1; pc_addr = 32'h300;
    #1; nxt();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    #1; nxt();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333; flush = 1'b1;
    #1; nxt();
    imem_rvalid = 1'b0; flush = 1'b0;
    #1; chk1("t8_no_push", id_valid, 1'b0); chk1("t8_idle", pc_ready, 1'b1);

    // Top-of-memory fetch.
    fetch0(32'hFFFFFFFC, 32'h0F0F0F0F);
    #1; chk32("t9_pc", id_pc, 32'hFFFFFFFC); chk32("t9_instr", id_instr, 32'h0F0F0F0F);
    nxt();

    // Randomized run against the reference model, starting from reset.
    #2; rst = 1'b1; #1; rst = 1'b0;
    mq.delete(); busy = 1'b0; granted = 1'b0; killed = 1'b0;
    m_pc = '0; m_addr = '0; m_pend = 1'b0; m_dly = 0; m_pdata = '0;
    nxt();
    for (int c = 0; c < 3000; c++) begin
      if (m_pend && m_dly == 0) begin imem_rvalid = 1'b1; imem_rdata = m_pdata; end
      else begin imem_rvalid = 1'b0; imem_rdata = $urandom; end
      imem_gnt = imem_req && !m_pend && ($urandom_range(0, 3) != 0);
      pc_valid = ($urandom_range(0, 2) != 0);
      pc_addr  = $urandom;
      id_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 11) == 0);
      #1;
      chk1("r_pc_ready", pc_ready, !busy && (mq.size() < DEPTH) && !flush);
      chk1("r_req", imem_req, busy && !granted);
      chk32("r_addr", imem_addr, m_addr);
      chk1("r_id_valid", id_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk32("r_id_pc", id_pc, mq[0].pc);
        chk32("r_id_instr", id_instr, mq[0].instr);
      end
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
